rr_lock_arb: RTL
================

# rr_lock_arb

Parametrised round-robin arbiter with burst lock, for the icache request paths. It merges WIDTH valid/ready requesters onto one valid/ready master port and rotates priority fairly. Once a requester starts a multi-beat burst, its grant is held until the burst's last beat. An optional output skid stage breaks the ready timing path. It replaces the fixed-priority arbiters on the miss/refill request paths.

## Interface
- WIDTH, 4: number of requesters, ≥2.
- PLD_TYPE, logic: payload type (struct from the shared package).
- IDX_W, $clog2(WIDTH): width of the grant index; derived, not overridden.

- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1), same port name as the rest of the codebase.
- v_vld_s  in  WIDTH  per-requester valid.
- v_rdy_s  out  WIDTH  per-requester ready; at most one bit set.
- v_pld_s  in  PLD_TYPE [WIDTH-1:0]  per-requester payload.
- v_last_s  in  WIDTH  per-requester last-beat flag; 1 means a single-beat transfer or the final beat of a burst.
- vld_m  out  1  master valid.
- rdy_m  in  1  master ready.
- pld_m  out  PLD_TYPE  granted payload.
- last_m  out  1  last flag of the granted beat.
- idx_m  out  IDX_W  index of the granted requester.

## Operation
- Requesters follow standard valid/ready rules: once vld is high, vld, pld and last stay stable until rdy.
- A beat transfers on requester i when v_vld_s[i] & v_rdy_s[i].
- Priority pointer ptr (IDX_W bits, reset 0) selects the highest-priority index.
- Winner is the first valid index found scanning ptr, ptr+1, … WIDTH-1, 0, …, with wrap-around.
- State machine has two states, IDLE and LOCK.
  - IDLE: arbitrate among all valid requesters.
    - Winner beat transfers with last=1: ptr ← (winner+1) mod WIDTH; stay in IDLE.
    - Winner beat transfers with last=0: lock_idx ← winner; go to LOCK; ptr unchanged.
  - LOCK: only lock_idx is eligible; all other v_rdy_s bits are 0, even if lock_idx is idle (vld low).
    - Beat with last=1 transfers: ptr ← (lock_idx+1) mod WIDTH; go to IDLE.
- No grant switches while a beat is pending: winner selection changes only after a transfer or when no request is valid.
- Payload is selected with a one-hot mux driven by the grant vector.
- rdy_m low holds all state; no beat is dropped.
- Reset asserted mid-burst: state ← IDLE, ptr ← 0, skid stage emptied; any in-flight beat is discarded.

## Timing
- Reset values: ptr=0, state IDLE, lock_idx=0, skid count=0.
  - With the skid macro: vld_m=0, last_m=0, idx_m=0, pld_m=0.
- Without the skid macro:
  - Combinational path, latency 0.
  - vld_m = winner valid.
  - v_rdy_s = grant & rdy_m.
- With the skid macro:
  - 2-entry skid buffer; latency 1 cycle from the requester transfer to vld_m.
  - Arbiter-side ready = (count<2), registered; no combinational path from rdy_m to v_rdy_s.
  - Full throughput: 1 beat per cycle while rdy_m=1.
  - Simultaneous push and pop leaves count unchanged.
  - When full, v_rdy_s=0 until a pop.
- ptr and state update in the cycle after the transfer edge; the new priority applies from the next arbitration.

## Configuration
- RR_LOCK_ARB_SKID_EN
  - Defined: 2-entry registered skid stage on the master side, with latency and ready behaviour as in Timing.
  - Undefined: pure combinational path from request to master; arbitration state logic is unchanged.

## Structure
- Shared package (icache_pkg) holds the requester payload struct and the IDX_W helper function.
- Natural sub-modules:
  - cmn_real_mux_onehot for payload selection.
  - rr_lock_arb_skid: the 2-entry buffer, instantiated only under the macro.
- Round-robin pick: double-width masked priority encode, in-module.

## Test plan
- Single-beat round robin: WIDTH=4, all four valid with last=1, rdy_m=1 → grant order 0,1,2,3,0; ptr wraps 3→0.
- Burst lock:
  - Stimulus: req1 sends 4 beats with last only on beat 4; req0 and req2 continuously valid.
  - Required response: idx_m=1 for 4 consecutive beats; next grant goes to 2.
- Lock with gap: req1 drops vld for 3 cycles mid-burst → no grant to others during the gap; burst resumes on idx 1.
- Backpressure:
  - Stimulus: rdy_m=0 for 5 cycles with req2 valid.
  - Required response: pld_m/idx_m held stable, no v_rdy_s pulse with skid full, no beat loss or duplication.
- Skid mode: macro defined, rdy_m toggling 1010… → vld_m 1 cycle after the first transfer; count never exceeds 2; output order matches grant order.
- Reset mid-burst:
  - Stimulus: rst_n=1 during beat 2 of a burst from req3.
  - Required response: after release, state IDLE, ptr=0; req0 wins when all are valid.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared icache request payload, arbiter state type and index-width helper
// Contents: icache_req_t (requester payload), arb_state_e (arbiter FSM states),
// idx_width() (bits needed to index n requesters).
package icache_pkg;

  typedef struct packed {
    logic [27:0] addr;
    logic [3:0]  tag;
  } icache_req_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_lock_arb_if.sv
// rtl/rr_lock_arb_if.sv - requester/master handshake bundle for rr_lock_arb
// Signals: v_vld_s/v_rdy_s/v_pld_s/v_last_s (per-requester side, WIDTH wide),
// vld_m/rdy_m/pld_m/last_m/idx_m (merged master side).
// Modports: slave (arbiter view), master (view of the agents around the arbiter).
interface rr_lock_arb_if #(
  parameter int  WIDTH    = 4,
  parameter type PLD_TYPE = logic
);
  import icache_pkg::*;

  localparam int IDX_W = idx_width(WIDTH);

  logic [WIDTH-1:0]    v_vld_s;
  logic [WIDTH-1:0]    v_rdy_s;
  PLD_TYPE [WIDTH-1:0] v_pld_s;
  logic [WIDTH-1:0]    v_last_s;
  logic                vld_m;
  logic                rdy_m;
  PLD_TYPE             pld_m;
  logic                last_m;
  logic [IDX_W-1:0]    idx_m;

  modport slave (
    input  v_vld_s, v_pld_s, v_last_s, rdy_m,
    output v_rdy_s, vld_m, pld_m, last_m, idx_m
  );

  modport master (
    output v_vld_s, v_pld_s, v_last_s, rdy_m,
    input  v_rdy_s, vld_m, pld_m, last_m, idx_m
  );

endinterface

// File: rtl/cmn_real_mux_onehot.sv
// rtl/cmn_real_mux_onehot.sv - AND-OR payload mux driven by a one-hot select
// Ports: i_sel (one-hot select, WIDTH), i_data (WIDTH payloads), o_data (selected payload,
// all zeros when i_sel is zero).
module cmn_real_mux_onehot #(
  parameter int  WIDTH    = 4,
  parameter type PLD_TYPE = logic
) (
  input  logic [WIDTH-1:0]    i_sel,
  input  PLD_TYPE [WIDTH-1:0] i_data,
  output PLD_TYPE             o_data
);

  localparam int DW = $bits(PLD_TYPE);

  logic [DW-1:0] w_acc;

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_acc = w_acc | (i_data[i] & {DW{i_sel[i]}});
    end
  end

  assign o_data = w_acc;

endmodule

// File: rtl/rr_lock_arb_skid.sv
// rtl/rr_lock_arb_skid.sv - 2-entry registered skid stage between arbiter and master port
// Used only when RR_LOCK_ARB_SKID_EN is defined.
// Ports: clk, rst_n (async, active-high); i_vld/i_pld/i_last/i_idx/o_rdy (arbiter side);
// o_vld/o_pld/o_last/o_idx/i_rdy (master side).
module rr_lock_arb_skid #(
  parameter type PLD_TYPE = logic,
  parameter int  IDX_W    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_vld,
  input  PLD_TYPE          i_pld,
  input  logic             i_last,
  input  logic [IDX_W-1:0] i_idx,
  output logic             o_rdy,
  output logic             o_vld,
  output PLD_TYPE          o_pld,
  output logic             o_last,
  output logic [IDX_W-1:0] o_idx,
  input  logic             i_rdy
);

  PLD_TYPE          r_pld  [2];
  logic             r_last [2];
  logic [IDX_W-1:0] r_idx  [2];
  logic             r_wr;
  logic             r_rd;
  logic [1:0]       r_cnt;
  logic             r_rdy;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;

  assign w_push    = i_vld & r_rdy;
  assign w_pop     = (r_cnt != 2'd0) & i_rdy;
  assign w_cnt_nxt = r_cnt + 2'(w_push) - 2'(w_pop);

  // Ready is a flop so rdy_m never reaches the requester ready path.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        r_pld[i]  <= '0;
        r_last[i] <= 1'b0;
        r_idx[i]  <= '0;
      end
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
      r_rdy <= 1'b1;
    end else begin
      if (w_push) begin
        r_pld[r_wr]  <= i_pld;
        r_last[r_wr] <= i_last;
        r_idx[r_wr]  <= i_idx;
        r_wr         <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_cnt <= w_cnt_nxt;
      r_rdy <= (w_cnt_nxt != 2'd2);
    end
  end

  assign o_rdy  = r_rdy;
  assign o_vld  = (r_cnt != 2'd0);
  assign o_pld  = r_pld[r_rd];
  assign o_last = r_last[r_rd];
  assign o_idx  = r_idx[r_rd];

endmodule

// File: rtl/rr_lock_arb.sv
// rtl/rr_lock_arb.sv - round-robin arbiter with burst lock for the icache request paths
// Ports: clk, rst_n (async, active-high); bus (rr_lock_arb_if.slave): per-requester
// v_vld_s/v_pld_s/v_last_s in, v_rdy_s out; master vld_m/pld_m/last_m/idx_m out, rdy_m in.
// Option: RR_LOCK_ARB_SKID_EN inserts rr_lock_arb_skid on the master side.
module rr_lock_arb
  import icache_pkg::*;
#(
  parameter int  WIDTH    = 4,
  parameter type PLD_TYPE = logic
) (
  input logic          clk,
  input logic          rst_n,
  rr_lock_arb_if.slave bus
);

  localparam int IDX_W = idx_width(WIDTH);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  arb_state_e       r_state;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_lock_idx;
  logic             r_hold;

  arb_state_e       w_state_nxt;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] w_lock_nxt;
  logic             w_hold_nxt;

  logic [WIDTH-1:0]   w_elig;
  logic [WIDTH-1:0]   w_mask;
  logic [2*WIDTH-1:0] w_dbl;
  logic               w_win_vld;
  logic [IDX_W-1:0]   w_win_idx;
  logic [WIDTH-1:0]   w_gnt;
  logic               w_arb_rdy;
  logic               w_xfer;
  logic               w_last;
  PLD_TYPE            w_pld;

  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] i_idx);
    return (int'(i_idx) == WIDTH - 1) ? '0 : i_idx + IDX_W'(1);
  endfunction

  // Inside a burst, or while an un-accepted beat is waiting, only r_lock_idx may win,
  // so the grant cannot move under a pending beat.
  // The low copy of w_dbl keeps only indices >= ptr; the first set bit across both
  // copies is the wrap-around winner.
  always_comb begin
    w_elig = bus.v_vld_s;
    if (r_state == ARB_LOCK || r_hold) begin
      w_elig = bus.v_vld_s & (ONE << r_lock_idx);
    end
    for (int i = 0; i < WIDTH; i++) begin
      w_mask[i] = (i >= int'(r_ptr));
    end
    w_dbl     = {w_elig, w_elig & w_mask};
    w_win_vld = |w_elig;
    w_win_idx = '0;
    for (int i = 2 * WIDTH - 1; i >= 0; i--) begin
      if (w_dbl[i]) begin
        w_win_idx = IDX_W'(i % WIDTH);
      end
    end
  end

  assign w_gnt       = w_win_vld ? (ONE << w_win_idx) : '0;
  assign bus.v_rdy_s = w_gnt & {WIDTH{w_arb_rdy}};
  assign w_xfer      = w_win_vld & w_arb_rdy;
  assign w_last      = |(w_gnt & bus.v_last_s);

  cmn_real_mux_onehot #(
    .WIDTH    (WIDTH),
    .PLD_TYPE (PLD_TYPE)
  ) u_pld_mux (
    .i_sel  (w_gnt),
    .i_data (bus.v_pld_s),
    .o_data (w_pld)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= ARB_IDLE;
      r_ptr      <= '0;
      r_lock_idx <= '0;
      r_hold     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_lock_idx <= w_lock_nxt;
      r_hold     <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_lock_nxt  = r_lock_idx;
    w_hold_nxt  = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        if (w_xfer) begin
          if (w_last) begin
            w_ptr_nxt = f_next(w_win_idx);
          end else begin
            w_lock_nxt  = w_win_idx;
            w_state_nxt = ARB_LOCK;
          end
        end else if (w_win_vld) begin
          w_hold_nxt = 1'b1;
          w_lock_nxt = w_win_idx;
        end
      end
      ARB_LOCK: begin
        if (w_xfer && w_last) begin
          w_ptr_nxt   = f_next(r_lock_idx);
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

`ifdef RR_LOCK_ARB_SKID_EN
  rr_lock_arb_skid #(
    .PLD_TYPE (PLD_TYPE),
    .IDX_W    (IDX_W)
  ) u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_vld  (w_win_vld),
    .i_pld  (w_pld),
    .i_last (w_last),
    .i_idx  (w_win_idx),
    .o_rdy  (w_arb_rdy),
    .o_vld  (bus.vld_m),
    .o_pld  (bus.pld_m),
    .o_last (bus.last_m),
    .o_idx  (bus.idx_m),
    .i_rdy  (bus.rdy_m)
  );
`else
  assign w_arb_rdy  = bus.rdy_m;
  assign bus.vld_m  = w_win_vld;
  assign bus.pld_m  = w_pld;
  assign bus.last_m = w_last;
  assign bus.idx_m  = w_win_idx;
`endif

endmodule
